// File: rtl/fight_pkg.sv
// Shared types for the fighting-game turn sequencer: action codes,
// sequencer states, winner codes and the end-of-turn winner rule.
package fight_pkg;

  typedef enum logic [2:0] {
    ACT_KICK   = 3'b000,
    ACT_PUNCH  = 3'b001,
    ACT_AWAIT  = 3'b010,
    ACT_JUMP   = 3'b011,
    ACT_LEFT1  = 3'b100,
    ACT_LEFT2  = 3'b101,
    ACT_RIGHT1 = 3'b110,
    ACT_RIGHT2 = 3'b111
  } action_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RST_P   = 3'd1,
    ST_COLLECT = 3'd2,
    ST_COMMIT  = 3'd3,
    ST_SETTLE  = 3'd4,
    ST_CHECK   = 3'd5,
    ST_OVER    = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_P1   = 2'b01,
    WIN_P2   = 2'b10,
    WIN_DRAW = 2'b11
  } winner_e;

  localparam logic [7:0] TURN_COUNT_SAT = 8'hFF;

  // A knocked-out player loses outright; only when nobody is out and the
  // turn limit is hit does the health comparison decide the game.
  function automatic winner_e decide_winner(input logic [1:0] h1,
                                            input logic [1:0] h2,
                                            input logic       at_limit);
    winner_e res;
    res = WIN_NONE;
    if (h1 == 2'd0 && h2 == 2'd0)  res = WIN_DRAW;
    else if (h2 == 2'd0)           res = WIN_P1;
    else if (h1 == 2'd0)           res = WIN_P2;
    else if (at_limit) begin
      if (h1 > h2)                 res = WIN_P1;
      else if (h2 > h1)            res = WIN_P2;
      else                         res = WIN_DRAW;
    end
    return res;
  endfunction

endpackage

// File: rtl/action_latch.sv
// First-wins capture of one player's action for the current turn.
// o_full/o_code_out look ahead: they already include a submit arriving this
// cycle, so the sequencer can commit on the same edge that captures it.
module action_latch
  import fight_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_clear,
  input  logic       i_valid,
  input  logic [2:0] i_code,
  input  logic       i_force_await,
  output logic       o_full,
  output logic [2:0] o_code_out
);

  logic       r_full;
  logic [2:0] r_code;

  // Hold the first submitted code; fill with await on timeout if still empty.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_full <= 1'b0;
      r_code <= ACT_AWAIT;
    end else if (i_clear) begin
      r_full <= 1'b0;
      r_code <= ACT_AWAIT;
    end else if (!r_full) begin
      if (i_valid) begin
        r_full <= 1'b1;
        r_code <= i_code;
      end else if (i_force_await) begin
        r_full <= 1'b1;
        r_code <= ACT_AWAIT;
      end
    end
  end

  assign o_full     = r_full | i_valid;
  assign o_code_out = r_full ? r_code : (i_valid ? i_code : ACT_AWAIT);

endmodule

// File: rtl/fight_turn_controller.sv
// Turn sequencer: collects one action per player, commits both with a
// shared enable strobe, waits for the player blocks to settle, then checks
// healths to decide whether the game continues or ends.
module fight_turn_controller
  import fight_pkg::*;
#(
  parameter int TURN_TICKS    = 250,
  parameter int ENABLE_CYCLES = 2,
  parameter int SETTLE_CYCLES = 2,
  parameter int MAX_TURNS     = 99
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_start,
  input  logic       i_act_valid1,
  input  logic [2:0] i_act_code1,
  input  logic       i_act_valid2,
  input  logic [2:0] i_act_code2,
  input  logic [1:0] i_health1,
  input  logic [1:0] i_health2,
  output logic [2:0] o_action1,
  output logic [2:0] o_action2,
  output logic       o_action_enable,
  output logic       o_players_rst_n,
  output logic       o_is_game_over,
  output logic [1:0] o_winner,
  output logic [7:0] o_turn_count
);

  localparam int TIMER_W   = (TURN_TICKS > 1) ? $clog2(TURN_TICKS) : 1;
  localparam int PHASE_MAX = (ENABLE_CYCLES > SETTLE_CYCLES) ? ENABLE_CYCLES : SETTLE_CYCLES;
  localparam int PHASE_W   = $clog2(PHASE_MAX + 1);

  localparam logic [TIMER_W-1:0] TIMER_LAST  = TIMER_W'(TURN_TICKS - 1);
  localparam logic [PHASE_W-1:0] ENABLE_LAST = PHASE_W'(ENABLE_CYCLES - 1);
  localparam logic [PHASE_W-1:0] SETTLE_LAST = PHASE_W'(SETTLE_CYCLES - 1);
  localparam logic [7:0]         TURN_LIMIT  = 8'(MAX_TURNS);

  state_e              r_state;
  logic [TIMER_W-1:0]  r_timer;
  logic [PHASE_W-1:0]  r_phase;
  logic [2:0]          r_action1;
  logic [2:0]          r_action2;
  logic                r_enable;
  logic                r_players_rst_n;
  logic                r_game_over;
  winner_e             r_winner;
  logic [7:0]          r_turn_count;

  logic                w_in_collect;
  logic                w_timeout;
  logic                w_clear;
  logic [1:0]          w_valid_raw;
  logic [1:0][2:0]     w_code_raw;
  logic [1:0]          w_full;
  logic [1:0][2:0]     w_code;
  logic                w_both_full;
  logic [7:0]          w_turn_next;
  winner_e             w_check_winner;

  assign w_in_collect   = (r_state == ST_COLLECT);
  assign w_timeout      = w_in_collect && (r_timer == TIMER_LAST);
  assign w_clear        = (r_state == ST_CHECK) || (r_state == ST_RST_P);
  assign w_valid_raw    = {i_act_valid2, i_act_valid1};
  assign w_code_raw     = {i_act_code2, i_act_code1};
  assign w_both_full    = &w_full;
  assign w_turn_next    = (r_turn_count == TURN_COUNT_SAT) ? r_turn_count : r_turn_count + 8'd1;
  assign w_check_winner = decide_winner(i_health1, i_health2, w_turn_next == TURN_LIMIT);

  // One capture latch per player; submits are only seen while collecting.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_player
      action_latch u_latch (
        .clk          (clk),
        .reset        (reset),
        .i_clear      (w_clear),
        .i_valid      (w_valid_raw[gi] && w_in_collect),
        .i_code       (w_code_raw[gi]),
        .i_force_await(w_timeout),
        .o_full       (w_full[gi]),
        .o_code_out   (w_code[gi])
      );
    end
  endgenerate

  // Turn sequencer with all outputs registered alongside the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state         <= ST_IDLE;
      r_timer         <= '0;
      r_phase         <= '0;
      r_action1       <= ACT_AWAIT;
      r_action2       <= ACT_AWAIT;
      r_enable        <= 1'b0;
      r_players_rst_n <= 1'b1;
      r_game_over     <= 1'b0;
      r_winner        <= WIN_NONE;
      r_turn_count    <= 8'd0;
    end else begin
      case (r_state)
        ST_IDLE, ST_OVER: begin
          if (i_start) begin
            r_state         <= ST_RST_P;
            r_players_rst_n <= 1'b0;
            r_turn_count    <= 8'd0;
            r_winner        <= WIN_NONE;
            r_game_over     <= 1'b0;
          end
        end
        ST_RST_P: begin
          r_players_rst_n <= 1'b1;
          r_timer         <= '0;
          r_state         <= ST_COLLECT;
        end
        ST_COLLECT: begin
          if (w_both_full || w_timeout) begin
            r_action1 <= w_code[0];
            r_action2 <= w_code[1];
            r_enable  <= 1'b1;
            r_phase   <= '0;
            r_state   <= ST_COMMIT;
          end else begin
            r_timer <= r_timer + TIMER_W'(1);
          end
        end
        ST_COMMIT: begin
          if (r_phase == ENABLE_LAST) begin
            r_enable <= 1'b0;
            r_phase  <= '0;
            r_state  <= ST_SETTLE;
          end else begin
            r_phase <= r_phase + PHASE_W'(1);
          end
        end
        ST_SETTLE: begin
          if (r_phase == SETTLE_LAST) begin
            r_phase <= '0;
            r_state <= ST_CHECK;
          end else begin
            r_phase <= r_phase + PHASE_W'(1);
          end
        end
        ST_CHECK: begin
          r_turn_count <= w_turn_next;
          if (w_check_winner != WIN_NONE) begin
            r_winner    <= w_check_winner;
            r_game_over <= 1'b1;
            r_state     <= ST_OVER;
          end else begin
            r_timer <= '0;
            r_state <= ST_COLLECT;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_action1       = r_action1;
  assign o_action2       = r_action2;
  assign o_action_enable = r_enable;
  assign o_players_rst_n = r_players_rst_n;
  assign o_is_game_over  = r_game_over;
  assign o_winner        = r_winner;
  assign o_turn_count    = r_turn_count;

endmodule

// File: tb/tb_fight_turn_controller.sv
// Scoreboard bench for the turn sequencer: each turn's expected committed
// actions are queued when submitted and compared when action_enable rises.
module tb_fight_turn_controller;

  localparam int TT  = 20;
  localparam int EN  = 2;
  localparam int ST  = 2;
  localparam int MAX = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       i_start = 1'b0;
  logic       i_act_valid1 = 1'b0;
  logic [2:0] i_act_code1 = 3'd0;
  logic       i_act_valid2 = 1'b0;
  logic [2:0] i_act_code2 = 3'd0;
  logic [1:0] i_health1 = 2'd3;
  logic [1:0] i_health2 = 2'd3;
  logic [2:0] o_action1;
  logic [2:0] o_action2;
  logic       o_action_enable;
  logic       o_players_rst_n;
  logic       o_is_game_over;
  logic [1:0] o_winner;
  logic [7:0] o_turn_count;

  int n_vectors = 0;
  int n_miscompares = 0;
  logic [5:0] exp_q[$];

  fight_turn_controller #(
    .TURN_TICKS   (TT),
    .ENABLE_CYCLES(EN),
    .SETTLE_CYCLES(ST),
    .MAX_TURNS    (MAX)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .i_start        (i_start),
    .i_act_valid1   (i_act_valid1),
    .i_act_code1    (i_act_code1),
    .i_act_valid2   (i_act_valid2),
    .i_act_code2    (i_act_code2),
    .i_health1      (i_health1),
    .i_health2      (i_health2),
    .o_action1      (o_action1),
    .o_action2      (o_action2),
    .o_action_enable(o_action_enable),
    .o_players_rst_n(o_players_rst_n),
    .o_is_game_over (o_is_game_over),
    .o_winner       (o_winner),
    .o_turn_count   (o_turn_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_vectors++;
    if (got != exp) begin
      n_miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s: %0d at %0t", tag, got, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_turns(input int n);
    int b = 0;
    while (o_turn_count != 8'(n) && b < 200) begin
      tick();
      b++;
    end
    check_eq("turn_count", int'(o_turn_count), n);
  endtask

  task automatic wait_over();
    int b = 0;
    while (!o_is_game_over && b < 200) begin
      tick();
      b++;
    end
    check_eq("game_over", int'(o_is_game_over), 1);
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    check_eq("rst_n_low", int'(o_players_rst_n), 0);
    check_eq("rst_turns", int'(o_turn_count), 0);
    check_eq("rst_over", int'(o_is_game_over), 0);
    check_eq("rst_winner", int'(o_winner), 0);
    tick();
    check_eq("rst_n_high", int'(o_players_rst_n), 1);
  endtask

  // Compare committed actions on each rising enable; check strobe width.
  int  mon_width = 0;
  logic mon_prev_en = 1'b0;
  always @(negedge clk) begin
    if (o_action_enable) begin
      if (!mon_prev_en) begin
        if (exp_q.size() == 0) begin
          check_eq("extra_enable", 1, 0);
        end else begin
          logic [5:0] e;
          e = exp_q.pop_front();
          check_eq("action1", int'(o_action1), int'(e[5:3]));
          check_eq("action2", int'(o_action2), int'(e[2:0]));
        end
        mon_width = 1;
      end else begin
        mon_width++;
      end
    end else if (mon_prev_en) begin
      check_eq("enable_width", mon_width, EN);
    end
    mon_prev_en = o_action_enable;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    repeat (3) tick();
    check_eq("reset_action1", int'(o_action1), 2);
    check_eq("reset_action2", int'(o_action2), 2);
    check_eq("reset_enable", int'(o_action_enable), 0);
    check_eq("reset_rst_n", int'(o_players_rst_n), 1);
    check_eq("reset_over", int'(o_is_game_over), 0);
    check_eq("reset_winner", int'(o_winner), 0);
    check_eq("reset_turns", int'(o_turn_count), 0);
    reset = 1'b1;
    tick();
    pulse_start();

    // Turn 1: P1 kick, later P2 punch; enable rises the cycle after P2
    repeat (4) tick();
    i_act_valid1 = 1'b1; i_act_code1 = 3'b000;
    tick();
    i_act_valid1 = 1'b0;
    repeat (3) tick();
    i_act_valid2 = 1'b1; i_act_code2 = 3'b001;
    exp_q.push_back({3'b000, 3'b001});
    check_eq("en_before_commit", int'(o_action_enable), 0);
    tick();
    i_act_valid2 = 1'b0;
    check_eq("en_latency", int'(o_action_enable), 1);
    wait_turns(1);

    // Turn 2: P1 left1 only; P2 times out to await
    i_act_valid1 = 1'b1; i_act_code1 = 3'b100;
    exp_q.push_back({3'b100, 3'b010});
    tick();
    i_act_valid1 = 1'b0;
    wait_turns(2);

    // Turn 3: P2 jump on the exact timeout cycle; healths 3/2 at limit -> P1
    i_health2 = 2'd2;
    repeat (TT - 1) tick();
    i_act_valid2 = 1'b1; i_act_code2 = 3'b011;
    exp_q.push_back({3'b010, 3'b011});
    check_eq("en_before_timeout", int'(o_action_enable), 0);
    tick();
    i_act_valid2 = 1'b0;
    check_eq("en_at_timeout", int'(o_action_enable), 1);
    wait_over();
    check_eq("limit_winner", int'(o_winner), 1);
    check_eq("limit_turns", int'(o_turn_count), 3);

    // New game: P1 double submit, stray valids during commit/settle
    i_health1 = 2'd3; i_health2 = 2'd3;
    pulse_start();
    i_act_valid1 = 1'b1; i_act_code1 = 3'b000;
    tick();
    i_act_code1 = 3'b001;
    tick();
    i_act_valid1 = 1'b0;
    tick();
    i_act_valid2 = 1'b1; i_act_code2 = 3'b111;
    exp_q.push_back({3'b000, 3'b111});
    tick();
    i_act_valid1 = 1'b1; i_act_code1 = 3'b110;
    i_act_valid2 = 1'b1; i_act_code2 = 3'b110;
    repeat (4) tick();
    i_act_valid1 = 1'b0; i_act_valid2 = 1'b0;
    wait_turns(1);

    // Turn 2 of that game: P2 knocked out -> P1 wins
    i_health2 = 2'd0;
    i_act_valid1 = 1'b1; i_act_code1 = 3'b000;
    i_act_valid2 = 1'b1; i_act_code2 = 3'b000;
    exp_q.push_back({3'b000, 3'b000});
    tick();
    i_act_valid1 = 1'b0; i_act_valid2 = 1'b0;
    wait_over();
    check_eq("ko_winner", int'(o_winner), 1);
    check_eq("ko_turns", int'(o_turn_count), 2);

    // Restart from OVER; both knocked out -> draw
    pulse_start();
    i_health1 = 2'd0; i_health2 = 2'd0;
    i_act_valid1 = 1'b1; i_act_code1 = 3'b011;
    i_act_valid2 = 1'b1; i_act_code2 = 3'b101;
    exp_q.push_back({3'b011, 3'b101});
    tick();
    i_act_valid1 = 1'b0; i_act_valid2 = 1'b0;
    wait_over();
    check_eq("draw_winner", int'(o_winner), 3);
    check_eq("draw_turns", int'(o_turn_count), 1);

    // Reset asserted during COMMIT aborts the turn
    i_health1 = 2'd3; i_health2 = 2'd3;
    pulse_start();
    i_act_valid1 = 1'b1; i_act_code1 = 3'b001;
    i_act_valid2 = 1'b1; i_act_code2 = 3'b001;
    tick();
    i_act_valid1 = 1'b0; i_act_valid2 = 1'b0;
    check_eq("abort_en_pre", int'(o_action_enable), 1);
    reset = 1'b0;
    #1;
    check_eq("abort_enable", int'(o_action_enable), 0);
    check_eq("abort_action1", int'(o_action1), 2);
    check_eq("abort_action2", int'(o_action2), 2);
    check_eq("abort_rst_n", int'(o_players_rst_n), 1);
    tick();
    reset = 1'b1;

    // Back in IDLE: submits without start must not commit
    i_act_valid1 = 1'b1; i_act_code1 = 3'b000;
    i_act_valid2 = 1'b1; i_act_code2 = 3'b000;
    tick();
    i_act_valid1 = 1'b0; i_act_valid2 = 1'b0;
    repeat (TT + 10) tick();
    check_eq("idle_enable", int'(o_action_enable), 0);
    check_eq("idle_turns", int'(o_turn_count), 0);
    check_eq("pending_expected", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
